operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 119 +++++++++++
 tb/tb_operand_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand fetch stage: 16 x W register file with writeback bypass, a busy
//   scoreboard for in-flight destinations, hazard detection and a registered
//   operand output that honours stall and flush.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      decoded instruction handshake
//   rs1, rs2                 source register addresses
//   use_rs1, use_rs2         source actually read (unused sources never hazard)
//   dest_en, dest            destination written back by this instruction
//   wb_en, wb_addr, wb_data  writeback port (always honoured)
//   stall                    downstream not ready, holds the output register
//   flush                    branch flush, kills output and pending issue
//   out_valid, op1, op2      registered operands
//   hazard                   combinational source/busy-destination conflict
module operand_fetch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   rs1,
  input  logic [3:0]   rs2,
  input  logic         use_rs1,
  input  logic         use_rs2,
  input  logic         dest_en,
  input  logic [3:0]   dest,
  input  logic         wb_en,
  input  logic [3:0]   wb_addr,
  input  logic [W-1:0] wb_data,
  input  logic         stall,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] op1,
  output logic [W-1:0] op2,
  output logic         hazard
);

  logic [W-1:0] regs [16];
  logic [15:0]  busy;
  logic [15:0]  busy_nxt;

  logic         wb_hit1;
  logic         wb_hit2;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic         hz1;
  logic         hz2;
  logic         accept;

  assign wb_hit1 = wb_en && (wb_addr == rs1);
  assign wb_hit2 = wb_en && (wb_addr == rs2);

  // Same-cycle writeback is forwarded so the issuing instruction never sees
  // the stale array value.
  assign rd1 = wb_hit1 ? wb_data : regs[rs1];
  assign rd2 = wb_hit2 ? wb_data : regs[rs2];

  // A busy source being written back this cycle is resolved by the bypass.
  assign hz1 = use_rs1 && busy[rs1] && !wb_hit1;
  assign hz2 = use_rs2 && busy[rs2] && !wb_hit2;

  assign hazard   = in_valid && (hz1 || hz2);
  assign in_ready = !hazard && !stall && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Clear first, then set, so a new acceptance wins over a same-cycle
  // writeback to the same register.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (accept && dest_en) begin
      busy_nxt[dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Flush overrides stall; stall freezes everything; otherwise the register
  // loads on acceptance and drops valid when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid <= 1'b1;
        op1       <= rd1;
        op2       <= rd2;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   rs1, rs2, dest, wb_addr;
  logic         use_rs1, use_rs2, dest_en, wb_en, stall, flush;
  logic [W-1:0] wb_data;
  logic         out_valid;
  logic [W-1:0] op1, op2;
  logic         hazard;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  operand_fetch #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .dest_en(dest_en), .dest(dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .op1(op1), .op2(op2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    dest_en = 0; dest = 0; wb_en = 0; wb_addr = 0; wb_data = '0;
    stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [3:0] a, input logic ua, input logic [3:0] b,
                       input logic ub, input logic de, input logic [3:0] d);
    in_valid = 1; rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub;
    dest_en = de; dest = d;
  endtask

  task automatic wb(input logic [3:0] a, input logic [W-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  // Monitor: a fresh output exists when out_valid is high after an edge at
  // which stall was low (a held output under stall is not a new result).
  initial begin
    logic s, r;
    logic [2*W-1:0] e;
    forever begin
      @(posedge clk);
      s = stall;
      r = rst;
      #2;
      if (!r && !s && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output op1=%h op2=%h expected=none", op1, op2);
        end else begin
          e = exp_q.pop_front();
          chk("sb_op1", op1, e[2*W-1:W]);
          chk("sb_op2", op2, e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1;
    cyc(); cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    rst = 0;

    // first cycle after reset
    issue(4'd3, 1, 4'd5, 1, 0, 0);
    in_valid = 0;
    wb(4'd3, 32'hDEADBEEF);
    #1;
    chk("post_rst_hazard", {31'b0, hazard}, 0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);
    cyc();

    // writeback then read next cycle
    wb_en = 0;
    issue(4'd3, 1, 4'd0, 1, 0, 0);
    exp_q.push_back({32'hDEADBEEF, 32'h0});
    cyc();
    idle();
    cyc();
    chk("valid_drop", {31'b0, out_valid}, 0);
    chk("valid_drop_op1_keep", op1, 32'hDEADBEEF);

    // same-cycle bypass
    issue(4'd3, 1, 4'd5, 1, 0, 0);
    wb(4'd5, 32'h12345678);
    #1;
    chk("bypass_hazard", {31'b0, hazard}, 0);
    exp_q.push_back({32'hDEADBEEF, 32'h12345678});
    cyc();
    idle();

    // RAW hazard on r7
    issue(4'd3, 1, 4'd5, 1, 1, 4'd7);
    exp_q.push_back({32'hDEADBEEF, 32'h12345678});
    cyc();
    issue(4'd7, 1, 4'd5, 1, 0, 0);
    #1;
    chk("raw_hazard", {31'b0, hazard}, 1);
    chk("raw_in_ready", {31'b0, in_ready}, 0);
    cyc();
    chk("raw_hazard_2", {31'b0, hazard}, 1);
    chk("raw_no_valid", {31'b0, out_valid}, 0);
    use_rs1 = 0;
    #1;
    chk("unused_src_no_hazard", {31'b0, hazard}, 0);
    use_rs1 = 1;
    wb(4'd7, 32'hA5);
    #1;
    chk("raw_wb_hazard", {31'b0, hazard}, 0);
    chk("raw_wb_in_ready", {31'b0, in_ready}, 1);
    exp_q.push_back({32'hA5, 32'h12345678});
    cyc();
    idle();

    // stall freeze
    issue(4'd3, 1, 4'd7, 1, 0, 0);
    exp_q.push_back({32'hDEADBEEF, 32'hA5});
    cyc();
    issue(4'd5, 1, 4'd5, 1, 1, 4'd4);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wb(4'd9, 32'h99);
      else wb_en = 0;
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 0);
      cyc();
      chk("stall_valid", {31'b0, out_valid}, 1);
      chk("stall_op1", op1, 32'hDEADBEEF);
      chk("stall_op2", op2, 32'hA5);
    end
    idle();
    issue(4'd9, 1, 4'd4, 1, 0, 0);
    #1;
    chk("stall_busy_unchanged", {31'b0, hazard}, 0);
    exp_q.push_back({32'h99, 32'h0});
    cyc();

    // flush overrides stall
    idle();
    stall = 1; flush = 1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 0);
    cyc();
    chk("flush_valid", {31'b0, out_valid}, 0);
    idle();

    // set wins over clear on r15
    issue(4'd15, 0, 4'd3, 1, 1, 4'd15);
    wb(4'd15, 32'hF0F0);
    exp_q.push_back({32'hF0F0, 32'hDEADBEEF});
    cyc();
    idle();
    issue(4'd15, 1, 4'd3, 1, 0, 0);
    #1;
    chk("set_wins_hazard", {31'b0, hazard}, 1);
    wb(4'd15, 32'h15);
    #1;
    chk("r15_clear_hazard", {31'b0, hazard}, 0);
    exp_q.push_back({32'h15, 32'hDEADBEEF});
    cyc();
    idle();

    // reset mid-stream
    issue(4'd3, 1, 4'd0, 0, 1, 4'd10);
    exp_q.push_back({32'hDEADBEEF, 32'h0});
    cyc();
    idle();
    #2;
    rst = 1;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_op1", op1, 0);
    chk("midrst_op2", op2, 0);
    cyc();
    rst = 0;
    issue(4'd3, 1, 4'd10, 1, 0, 0);
    #1;
    chk("midrst_busy_cleared", {31'b0, hazard}, 0);
    exp_q.push_back({32'h0, 32'h0});
    cyc();
    idle();
    cyc(); cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
